relay_pulse_sequencer: RTL

Timed H-bridge pulse sequencer for the four latching bidirectional-IO relays. It sits between the relay control register logic and the `relay_a`/`relay_b` pins. It accepts one direction command at a time and drives exactly one coil pulse of fixed length, followed by a dead time. It reports the resulting latched state on `relay_state`, which feeds the management status path. Only one relay is ever energized at a time, which limits coil supply current.

---
 rtl/relay_pulse_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/relay_pulse_sequencer.sv
// Timed H-bridge pulse sequencer for four latching relays: one coil pulse per command, then dead time.
// Optional power-on B-side sweep of all channels is enabled with `define RELAY_POWERON_INIT_EN.
module relay_pulse_sequencer #(
    parameter int PULSE_CYCLES = 625000,
    parameter int DEAD_CYCLES  = 125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_channel,
    input  logic       req_dir,
    output logic       busy,
    output logic       done,
    output logic [3:0] relay_state,
    output logic [3:0] relay_a,
    output logic [3:0] relay_b
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES : DEAD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef RELAY_POWERON_INIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DEAD = 2'd2, S_INIT = 2'd3} state_t;
    localparam state_t RST_STATE = S_INIT;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DEAD = 2'd2} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [1:0]       r_ch, w_ch_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_ready, r_busy, r_done;
    logic [3:0]       r_relay_state, r_relay_a, r_relay_b;
    logic             w_pulse_end, w_dead_end;
    logic [3:0]       w_onehot_nxt;
    logic             w_suppress_done;

`ifdef RELAY_POWERON_INIT_EN
    logic r_init, w_init_nxt;
    assign w_suppress_done = r_init;
`else
    assign w_suppress_done = 1'b0;
`endif

    assign w_pulse_end  = (r_state == S_DRIVE) && (r_count == PULSE_LAST);
    assign w_dead_end   = (r_state == S_DEAD) && (r_count == DEAD_LAST);
    assign w_onehot_nxt = 4'b0001 << w_ch_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ch_nxt    = r_ch;
        w_dir_nxt   = r_dir;
`ifdef RELAY_POWERON_INIT_EN
        w_init_nxt  = r_init;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_state_nxt = S_DRIVE;
                    w_ch_nxt    = req_channel;
                    w_dir_nxt   = req_dir;
                    w_count_nxt = '0;
                end
            end
            S_DRIVE: begin
                if (w_pulse_end) begin
                    w_state_nxt = S_DEAD;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            S_DEAD: begin
                if (w_dead_end) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
`ifdef RELAY_POWERON_INIT_EN
                    // Power-on sweep chains straight into the next channel's pulse.
                    if (r_init && (r_ch != 2'd3)) begin
                        w_state_nxt = S_DRIVE;
                        w_ch_nxt    = r_ch + 2'd1;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_init_nxt  = 1'b0;
                    end
`endif
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
`ifdef RELAY_POWERON_INIT_EN
            S_INIT: begin
                w_state_nxt = S_DRIVE;
                w_ch_nxt    = 2'd0;
                w_dir_nxt   = 1'b0;
                w_count_nxt = '0;
                w_init_nxt  = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RST_STATE;
            r_count       <= '0;
            r_relay_a     <= 4'h0;
            r_relay_b     <= 4'h0;
            r_relay_state <= 4'h0;
            r_done        <= 1'b0;
`ifdef RELAY_POWERON_INIT_EN
            r_init        <= 1'b0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b1;
`else
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_relay_a <= (w_state_nxt == S_DRIVE && w_dir_nxt)  ? w_onehot_nxt : 4'h0;
            r_relay_b <= (w_state_nxt == S_DRIVE && !w_dir_nxt) ? w_onehot_nxt : 4'h0;
            if (w_pulse_end) begin
                r_relay_state[r_ch] <= r_dir;
            end
            r_done    <= w_pulse_end && !w_suppress_done;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
`ifdef RELAY_POWERON_INIT_EN
            r_init    <= w_init_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        r_ch  <= w_ch_nxt;
        r_dir <= w_dir_nxt;
    end

    assign req_ready   = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign relay_state = r_relay_state;
    assign relay_a     = r_relay_a;
    assign relay_b     = r_relay_b;

endmodule
